pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard, forwarding and pipeline-control unit for the 5-stage IF/ID/EX/MEM/WB core.
- Replaces the scattered PCWrite/freeze/flush/hzdetect logic with one block.
- Keeps shadow copies of the EX/MEM/WB destination info and drives stall, bubble, flush, freeze and forwarding selects.
- Adds what the current core lacks: optional forwarding, configurable branch penalty, a multi-cycle data-memory wait with timeout, and a stall-cycle counter.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_fwd_unit.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the hazard/forwarding control block.
package pipe_pkg;

    // Shadow register fields are stored at this width; narrower cores zero-extend.
    localparam int unsigned REG_AW_MAX = 8;

    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  regwrite;
        logic                  memread;
        logic [REG_AW_MAX-1:0] rs;
        logic [REG_AW_MAX-1:0] rt;
    } shadow_t;

    // A writer matches a source only for a nonzero register address.
    function automatic logic reg_match(input logic wr,
                                       input logic [REG_AW_MAX-1:0] rd,
                                       input logic [REG_AW_MAX-1:0] src);
        return wr && (src != '0) && (rd == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bus between the core datapath and the hazard unit.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_regwrite;
    logic              id_memread;
    logic              ex_br_taken;
    logic              mem_req;
    logic              mem_ready;
    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              freeze;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_regwrite, id_memread,
               ex_br_taken, mem_req, mem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, freeze,
               fwd_a, fwd_b, mem_err, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_regwrite, id_memread,
               ex_br_taken, mem_req, mem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, freeze,
               fwd_a, fwd_b, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipe_fwd_unit.sv
// Forwarding select for one EX operand: youngest matching writer wins.
module pipe_fwd_unit
    import pipe_pkg::*;
#(
    parameter int unsigned FWD_EN = 1
) (
    input  logic [REG_AW_MAX-1:0] src,
    input  shadow_t               mem_e,
    input  shadow_t               wb_e,
    output fwd_sel_t              sel
);

    // Only destination info of the older stages matters here.
    logic unused_fields;
    assign unused_fields = ^{mem_e.memread, mem_e.rs, mem_e.rt,
                             wb_e.memread, wb_e.rs, wb_e.rt};

    // MEM result is newer than WB, so it takes priority.
    always_comb begin
        sel = FWD_REG;
        if (FWD_EN != 0) begin
            if (reg_match(mem_e.valid && mem_e.regwrite, mem_e.rd, src)) begin
                sel = FWD_MEM;
            end else if (reg_match(wb_e.valid && wb_e.regwrite, wb_e.rd, src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, forwarding and stall/flush/freeze control for the 5-stage core.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned FWD_EN      = 1,
    parameter int unsigned BR_PENALTY  = 1,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e                state_q, state_d, prior_q, prior_d, eff;
    logic [1:0]            flush_q, flush_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  abort_q, abort_d, err_q, err_set;
    logic [CNT_W-1:0]      stall_q;
    shadow_t               ex_q, mem_q, wb_q, ex_new;
    logic [REG_AW_MAX-1:0] id_rs_x, id_rt_x;
    logic                  hz_rs, hz_rt, hazard, in_wait, timeout;
    logic                  pc_write, ifid_write, ifid_flush, idex_bubble, freeze;
    fwd_sel_t              fwd_a, fwd_b;

    assign id_rs_x = REG_AW_MAX'(bus.id_rs[REG_AW-1:0]);
    assign id_rt_x = REG_AW_MAX'(bus.id_rt[REG_AW-1:0]);
    assign in_wait = (state_q == MEM_WAIT);
    assign eff     = in_wait ? prior_q : state_q;
    assign timeout = in_wait && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    // RAW check of the ID sources against in-flight writers (WB is write-before-read).
    always_comb begin
        hz_rs = 1'b0;
        hz_rt = 1'b0;
        if (FWD_EN != 0) begin
            hz_rs = reg_match(ex_q.valid && ex_q.memread, ex_q.rd, id_rs_x);
            hz_rt = reg_match(ex_q.valid && ex_q.memread, ex_q.rd, id_rt_x);
        end else begin
            hz_rs = reg_match(ex_q.valid && ex_q.regwrite, ex_q.rd, id_rs_x) ||
                    reg_match(mem_q.valid && mem_q.regwrite, mem_q.rd, id_rs_x);
            hz_rt = reg_match(ex_q.valid && ex_q.regwrite, ex_q.rd, id_rt_x) ||
                    reg_match(mem_q.valid && mem_q.regwrite, mem_q.rd, id_rt_x);
        end
        hazard = (bus.id_use_rs && hz_rs) || (bus.id_use_rt && hz_rt);
    end

    // Next state and control outputs; priority is freeze > branch flush > load-use stall.
    always_comb begin
        state_d     = state_q;
        prior_d     = prior_q;
        flush_d     = flush_q;
        wait_d      = wait_q;
        abort_d     = abort_q && bus.mem_req;
        err_set     = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        // A timed-out access must not re-freeze until the requester drops mem_req.
        if (in_wait) begin
            freeze = !bus.mem_ready;
        end else begin
            freeze = bus.mem_req && !bus.mem_ready && !abort_q;
        end
        if (freeze) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            if (!in_wait) begin
                state_d = MEM_WAIT;
                prior_d = state_q;
                wait_d  = WAIT_W'(1);
            end else if (timeout) begin
                state_d = prior_q;
                wait_d  = '0;
                err_set = 1'b1;
                abort_d = 1'b1;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end else begin
            if (in_wait) begin
                state_d = prior_q;
                wait_d  = '0;
            end
            case (eff)
                RUN: begin
                    if (bus.ex_br_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        state_d     = FLUSH;
                        flush_d     = 2'(BR_PENALTY - 1);
                    end
                end
                FLUSH: begin
                    if (flush_q != 2'd0) begin
                        ifid_flush = 1'b1;
                        flush_d    = flush_q - 2'd1;
                    end
                    state_d = (flush_q <= 2'd1) ? RUN : FLUSH;
                end
                default: ;
            endcase
            if (hazard && !ifid_flush) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    // Entry that the ID instruction becomes in EX, or a bubble.
    always_comb begin
        ex_new = '0;
        if (!idex_bubble && !ifid_flush) begin
            ex_new.valid    = 1'b1;
            ex_new.rd       = REG_AW_MAX'(bus.id_rd[REG_AW-1:0]);
            ex_new.regwrite = bus.id_regwrite;
            ex_new.memread  = bus.id_memread;
            ex_new.rs       = id_rs_x;
            ex_new.rt       = id_rt_x;
        end
    end

    // FSM, wait/flush counters, sticky error and stall counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            prior_q <= RUN;
            flush_q <= '0;
            wait_q  <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            prior_q <= prior_d;
            flush_q <= flush_d;
            wait_q  <= wait_d;
            abort_q <= abort_d;
            err_q   <= err_q | err_set;
            if (!pc_write && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    // Shadow copy of EX/MEM/WB destination info, held while frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!freeze) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_new;
        end
    end

    pipe_fwd_unit #(.FWD_EN(FWD_EN)) u_fwd_a (
        .src   (ex_q.rs),
        .mem_e (mem_q),
        .wb_e  (wb_q),
        .sel   (fwd_a)
    );

    pipe_fwd_unit #(.FWD_EN(FWD_EN)) u_fwd_b (
        .src   (ex_q.rt),
        .mem_e (mem_q),
        .wb_e  (wb_q),
        .sel   (fwd_b)
    );

    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.freeze      = freeze;
    assign bus.fwd_a       = fwd_a;
    assign bus.fwd_b       = fwd_b;
    assign bus.mem_err     = err_q;
    assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench: dut_a forwards (penalty 2, timeout 8), dut_b stalls (penalty 1).
module tb_pipe_hazard_ctrl;

    localparam int PCW = 0, IFW = 1, FLS = 2, BUB = 3, FRZ = 4;
    localparam int FA = 5, FB = 6, ERR = 7, CNT = 8, B = 16;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    logic clk = 1'b0;
    logic reset;
    chk_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ia ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ib ();

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .BR_PENALTY(2), .MEM_TIMEOUT(8), .CNT_W(16))
        dut_a (.clk(clk), .reset(reset), .bus(ia));

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .BR_PENALTY(1), .MEM_TIMEOUT(64), .CNT_W(16))
        dut_b (.clk(clk), .reset(reset), .bus(ib));

    function automatic logic [31:0] obs(input int sel);
        logic [31:0] v;
        v = '0;
        case (sel)
            PCW:     v = 32'(ia.pc_write);
            IFW:     v = 32'(ia.ifid_write);
            FLS:     v = 32'(ia.ifid_flush);
            BUB:     v = 32'(ia.idex_bubble);
            FRZ:     v = 32'(ia.freeze);
            FA:      v = 32'(ia.fwd_a);
            FB:      v = 32'(ia.fwd_b);
            ERR:     v = 32'(ia.mem_err);
            CNT:     v = 32'(ia.stall_cnt);
            B + PCW: v = 32'(ib.pc_write);
            B + IFW: v = 32'(ib.ifid_write);
            B + FLS: v = 32'(ib.ifid_flush);
            B + BUB: v = 32'(ib.idex_bubble);
            B + FRZ: v = 32'(ib.freeze);
            B + FA:  v = 32'(ib.fwd_a);
            B + FB:  v = 32'(ib.fwd_b);
            B + ERR: v = 32'(ib.mem_err);
            B + CNT: v = 32'(ib.stall_cnt);
            default: v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        chk_t c;
        c.tag = tag;
        c.sel = sel;
        c.exp = v;
        sb.push_back(c);
    endtask

    task automatic drain();
        chk_t        c;
        logic [31:0] o;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            o = obs(c.sel);
            total++;
            assert (o === c.exp) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", c.tag, o, c.exp);
            end
        end
    endtask

    // Outputs are settled at the falling edge; inputs change just after the rising edge.
    task automatic tick();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input int rs, input int rt, input bit urs, input bit urt,
                            input int rd, input bit rw, input bit mr);
        ia.id_rs = 5'(rs);  ib.id_rs = 5'(rs);
        ia.id_rt = 5'(rt);  ib.id_rt = 5'(rt);
        ia.id_rd = 5'(rd);  ib.id_rd = 5'(rd);
        ia.id_use_rs = urs; ib.id_use_rs = urs;
        ia.id_use_rt = urt; ib.id_use_rt = urt;
        ia.id_regwrite = rw; ib.id_regwrite = rw;
        ia.id_memread = mr; ib.id_memread = mr;
    endtask

    task automatic ctl(input bit br, input bit req, input bit rdy);
        ia.ex_br_taken = br;  ib.ex_br_taken = br;
        ia.mem_req = req;     ib.mem_req = req;
        ia.mem_ready = rdy;   ib.mem_ready = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0);
        ctl(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        do_reset();

        // Reset values on both instances
        push("rst_pcw", PCW, 1);   push("rst_ifw", IFW, 1);  push("rst_fls", FLS, 0);
        push("rst_bub", BUB, 0);   push("rst_frz", FRZ, 0);  push("rst_fa", FA, 0);
        push("rst_fb", FB, 0);     push("rst_err", ERR, 0);  push("rst_cnt", CNT, 0);
        push("rst_b_pcw", B + PCW, 1); push("rst_b_ifw", B + IFW, 1);
        push("rst_b_bub", B + BUB, 0); push("rst_b_cnt", B + CNT, 0);
        tick();

        // Load r5 followed by a use of r5: one bubble, then WB forwarding
        do_reset();
        drive_id(1, 0, 1, 0, 5, 1, 1);
        push("lu_c1_pcw", PCW, 1); push("lu_c1_bub", BUB, 0);
        tick();
        drive_id(5, 1, 1, 1, 6, 1, 0);
        push("lu_c2_pcw", PCW, 0); push("lu_c2_ifw", IFW, 0); push("lu_c2_bub", BUB, 1);
        tick();
        push("lu_c3_pcw", PCW, 1); push("lu_c3_bub", BUB, 0); push("lu_c3_cnt", CNT, 1);
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        push("lu_fa_wb", FA, 2); push("lu_fb_reg", FB, 0); push("lu_cnt", CNT, 1);
        tick();

        // add r3 ; sub r4=r3-r3 back to back: MEM forwarding, no stall; r0 never forwarded
        do_reset();
        drive_id(1, 2, 1, 1, 3, 1, 0);
        push("as_c1_pcw", PCW, 1);
        tick();
        drive_id(3, 3, 1, 1, 4, 1, 0);
        push("as_c2_pcw", PCW, 1); push("as_c2_bub", BUB, 0);
        tick();
        drive_id(1, 2, 1, 1, 0, 1, 0);
        push("as_fa_mem", FA, 1); push("as_fb_mem", FB, 1);
        tick();
        drive_id(0, 0, 1, 1, 5, 1, 0);
        push("as_c4_fa", FA, 0); push("as_c4_fb", FB, 0); push("as_c4_pcw", PCW, 1);
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        push("as_r0_fa", FA, 0); push("as_r0_fb", FB, 0); push("as_cnt", CNT, 0);
        tick();

        // Same pair without forwarding: two stall cycles on dut_b
        do_reset();
        drive_id(1, 2, 1, 1, 3, 1, 0);
        push("nf_c1_pcw", B + PCW, 1);
        tick();
        drive_id(3, 3, 1, 1, 4, 1, 0);
        push("nf_c2_pcw", B + PCW, 0); push("nf_c2_bub", B + BUB, 1);
        tick();
        push("nf_c3_pcw", B + PCW, 0); push("nf_c3_bub", B + BUB, 1);
        tick();
        push("nf_c4_pcw", B + PCW, 1); push("nf_c4_bub", B + BUB, 0);
        push("nf_c4_cnt", B + CNT, 2);
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        push("nf_fa", B + FA, 0); push("nf_fb", B + FB, 0); push("nf_cnt", B + CNT, 2);
        tick();

        // Taken branch over a load-use hazard: flush wins, penalty 2 on dut_a, 1 on dut_b
        do_reset();
        drive_id(1, 0, 1, 0, 5, 1, 1);
        tick();
        drive_id(5, 1, 1, 1, 6, 1, 0);
        ctl(1, 0, 0);
        push("br_c1_fls", FLS, 1); push("br_c1_bub", BUB, 1);
        push("br_c1_pcw", PCW, 1); push("br_c1_ifw", IFW, 1);
        push("br_b_c1_fls", B + FLS, 1); push("br_b_c1_pcw", B + PCW, 1);
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        ctl(0, 0, 0);
        push("br_c2_fls", FLS, 1); push("br_c2_bub", BUB, 0); push("br_c2_pcw", PCW, 1);
        push("br_b_c2_fls", B + FLS, 0);
        tick();
        push("br_c3_fls", FLS, 0); push("br_c3_pcw", PCW, 1); push("br_c3_cnt", CNT, 0);
        tick();

        // Five-cycle memory wait: freeze holds the shadow pipeline
        do_reset();
        drive_id(1, 2, 1, 1, 3, 1, 0);
        tick();
        drive_id(3, 3, 1, 1, 4, 1, 0);
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        ctl(0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            push("mw_frz", FRZ, 1); push("mw_pcw", PCW, 0);
            push("mw_fa_held", FA, 1); push("mw_fb_held", FB, 1);
            tick();
        end
        ctl(0, 1, 1);
        push("mw_rdy_frz", FRZ, 0); push("mw_rdy_pcw", PCW, 1);
        push("mw_rdy_fa", FA, 1); push("mw_cnt", CNT, 5);
        tick();
        ctl(0, 0, 0);
        push("mw_end_frz", FRZ, 0); push("mw_end_fa", FA, 0);
        push("mw_end_cnt", CNT, 5); push("mw_end_err", ERR, 0);
        tick();

        // Memory timeout after 8 cycles, sticky error, then async reset mid-wait
        do_reset();
        ctl(0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            push("to_frz", FRZ, 1); push("to_err", ERR, 0); push("to_cnt", CNT, 32'(i - 1));
            tick();
        end
        push("to_rel_frz", FRZ, 0); push("to_rel_err", ERR, 1);
        push("to_rel_pcw", PCW, 1); push("to_rel_cnt", CNT, 8);
        tick();
        push("to_hold_frz", FRZ, 0); push("to_hold_err", ERR, 1);
        tick();
        ctl(0, 0, 0);
        push("to_idle_err", ERR, 1);
        tick();
        ctl(0, 1, 0);
        push("to_w2_frz", FRZ, 1); push("to_w2_err", ERR, 1);
        tick();
        @(negedge clk);
        push("to_w2b_frz", FRZ, 1); push("to_w2b_cnt", CNT, 9);
        drain();
        #2;
        reset = 1'b0;
        ctl(0, 0, 0);
        #1;
        push("ar_err", ERR, 0); push("ar_cnt", CNT, 0); push("ar_frz", FRZ, 0);
        push("ar_pcw", PCW, 1); push("ar_fa", FA, 0);
        drain();
        @(posedge clk);
        #1;
        reset = 1'b1;
        push("ar_post_frz", FRZ, 0); push("ar_post_err", ERR, 0); push("ar_post_cnt", CNT, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
